// File: rtl/pet_pkg.sv
// Shared mood encodings and display_out field layout for the pet stats engine.
// Pure type/constant package; no logic, no latency.
package pet_pkg;

    typedef enum logic [1:0] {
        MOOD_OK   = 2'b00,
        MOOD_WARN = 2'b01,
        MOOD_CRIT = 2'b10,
        MOOD_DEAD = 2'b11
    } mood_e;

    // display_out = {mood[1:0], idx[1:0]}
    typedef struct packed {
        mood_e      mood;
        logic [1:0] idx;
    } disp_t;

    localparam int DISP_W = $bits(disp_t);

endpackage

// File: rtl/pet_stat_channel.sv
// One need channel: saturating level plus tick-driven decay counter; revive > stim > decay.
// Level updates one cycle after stim/revive/decay event; no backpressure.
module pet_stat_channel
    import pet_pkg::*;
#(
    parameter int STAT_W      = 3,
    parameter int MAX_LEVEL   = 5,
    parameter int INIT_LEVEL  = 5,
    parameter int DECAY_TICKS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick,
    input  logic              i_stim,
    input  logic              i_revive,
    input  logic              i_freeze,
    output logic [STAT_W-1:0] o_level
);

    localparam int CNT_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

    logic [STAT_W-1:0] r_level;
    logic [CNT_W-1:0]  r_dcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= STAT_W'(INIT_LEVEL);
            r_dcnt  <= '0;
        end else if (i_revive) begin
            r_level <= STAT_W'(INIT_LEVEL);
            r_dcnt  <= '0;
        end else if (!i_freeze) begin
            // Care beats a coincident decay: the counter restarts and the level only rises.
            if (i_stim) begin
                if (r_level < STAT_W'(MAX_LEVEL)) begin
                    r_level <= r_level + 1'b1;
                end
                r_dcnt <= '0;
            end else if (i_tick) begin
                if (r_dcnt == CNT_W'(DECAY_TICKS - 1)) begin
                    r_dcnt <= '0;
                    if (r_level != '0) begin
                        r_level <= r_level - 1'b1;
                    end
                end else begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/pet_stats_engine.sv
// Virtual-pet need tracker: tick prescaler, NUM_STATS decaying channels, mood FSM, display code.
// tick is combinational in the wrap cycle; display_out/alarm lag the mood state by one cycle; no backpressure.
module pet_stats_engine
    import pet_pkg::*;
#(
    parameter int NUM_STATS   = 4,
    parameter int STAT_W      = 3,
    parameter int MAX_LEVEL   = 5,
    parameter int INIT_LEVEL  = 5,
    parameter int WARN_LVL    = 2,
    parameter int TICK_DIV    = 50000000,
    parameter int TEST_DIV    = 20000,
    parameter int DECAY_TICKS = 10,
    parameter int DEAD_TICKS  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_STATS-1:0]        stim,
    input  logic                        test,
    input  logic                        pause,
    input  logic                        revive,
    output logic [NUM_STATS*STAT_W-1:0] levels,
    output logic [DISP_W-1:0]           display_out,
    output logic                        tick,
    output logic                        alarm
);

    localparam int MAX_DIV = (TICK_DIV > TEST_DIV) ? TICK_DIV : TEST_DIV;
    localparam int PW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam int CW      = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

    logic [PW-1:0]     r_presc;
    logic              r_test_q;
    mood_e             r_state;
    logic [CW-1:0]     r_crit_cnt;
    disp_t             r_disp;
    logic              r_alarm;

    logic [PW-1:0]     w_div_m1;
    logic              w_test_chg;
    logic              w_wrap;
    logic              w_tick;
    logic              w_dead;
    logic [STAT_W-1:0] w_lvl [NUM_STATS];
    logic              w_any_zero;
    logic              w_any_warn;
    logic [1:0]        w_zero_idx;
    logic [1:0]        w_warn_idx;
    logic [1:0]        w_idx;
    mood_e             w_nstate;
    logic [CW-1:0]     w_ncrit;

    // Prescaler; a mode switch restarts the count so the new period starts cleanly.
    assign w_div_m1   = test ? PW'(TEST_DIV - 1) : PW'(TICK_DIV - 1);
    assign w_test_chg = test ^ r_test_q;
    assign w_wrap     = (r_presc == w_div_m1);
    assign w_tick     = w_wrap && !pause && !w_test_chg;
    assign tick       = w_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc  <= '0;
            r_test_q <= 1'b0;
        end else begin
            r_test_q <= test;
            if (w_test_chg) begin
                r_presc <= '0;
            end else if (!pause) begin
                r_presc <= w_wrap ? '0 : r_presc + 1'b1;
            end
        end
    end

    assign w_dead = (r_state == MOOD_DEAD);

    for (genvar g = 0; g < NUM_STATS; g++) begin : g_ch
        pet_stat_channel #(
            .STAT_W      (STAT_W),
            .MAX_LEVEL   (MAX_LEVEL),
            .INIT_LEVEL  (INIT_LEVEL),
            .DECAY_TICKS (DECAY_TICKS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_tick   (w_tick),
            .i_stim   (stim[g]),
            .i_revive (revive),
            .i_freeze (w_dead),
            .o_level  (w_lvl[g])
        );
        assign levels[g*STAT_W +: STAT_W] = w_lvl[g];
    end

    // Scan from the top so the lowest matching channel index is what remains.
    always_comb begin
        w_any_zero = 1'b0;
        w_any_warn = 1'b0;
        w_zero_idx = '0;
        w_warn_idx = '0;
        for (int i = NUM_STATS - 1; i >= 0; i--) begin
            if (w_lvl[i] == '0) begin
                w_any_zero = 1'b1;
                w_zero_idx = 2'(i);
            end
            if (w_lvl[i] <= STAT_W'(WARN_LVL)) begin
                w_any_warn = 1'b1;
                w_warn_idx = 2'(i);
            end
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_ncrit  = r_crit_cnt;
        if (revive) begin
            w_nstate = MOOD_OK;
            w_ncrit  = '0;
        end else if (r_state != MOOD_DEAD) begin
            if (w_any_zero) begin
                w_nstate = MOOD_CRIT;
                if (r_state == MOOD_CRIT && w_tick) begin
                    if (w_ncrit == CW'(DEAD_TICKS - 1)) begin
                        w_nstate = MOOD_DEAD;
                        w_ncrit  = '0;
                    end else begin
                        w_ncrit = r_crit_cnt + 1'b1;
                    end
                end
            end else begin
                w_ncrit  = '0;
                w_nstate = w_any_warn ? MOOD_WARN : MOOD_OK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= MOOD_OK;
            r_crit_cnt <= '0;
        end else begin
            r_state    <= w_nstate;
            r_crit_cnt <= w_ncrit;
        end
    end

    always_comb begin
        w_idx = '0;
        case (r_state)
            MOOD_CRIT, MOOD_DEAD: w_idx = w_zero_idx;
            MOOD_WARN:            w_idx = w_warn_idx;
            default:              w_idx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disp  <= '0;
            r_alarm <= 1'b0;
        end else begin
            r_disp.mood <= r_state;
            r_disp.idx  <= w_idx;
            r_alarm     <= (r_state == MOOD_CRIT) || (r_state == MOOD_DEAD);
        end
    end

    assign display_out = r_disp;
    assign alarm       = r_alarm;

endmodule

// File: doc/pet_stats_engine.md
PET_STATS_ENGINE -- requirements
Module: pet_stats_engine

Interface
REQ-001 SHALL have parameter NUM_STATS, default 4, number of need channels (legal 1..4).
REQ-002 SHALL have parameter STAT_W, default 3, level width in bits.
REQ-003 SHALL have parameter MAX_LEVEL, default 5, saturation ceiling (< 2**STAT_W).
REQ-004 SHALL have parameter INIT_LEVEL, default 5, level after reset or revive.
REQ-005 SHALL have parameter WARN_LVL, default 2, warning threshold (level <= WARN_LVL).
REQ-006 SHALL have parameter TICK_DIV, default 50000000, clk cycles per tick in normal mode.
REQ-007 SHALL have parameter TEST_DIV, default 20000, clk cycles per tick in test mode.
REQ-008 SHALL have parameter DECAY_TICKS, default 10, ticks between decrements per channel.
REQ-009 SHALL have parameter DEAD_TICKS, default 5, ticks in CRIT before DEAD.
REQ-010 SHALL have port clk, input, 1, sole clock.
REQ-011 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-012 SHALL have port stim, input, NUM_STATS, one-cycle care pulses, bit i feeds channel i.
REQ-013 SHALL have port test, input, 1, level: selects TEST_DIV.
REQ-014 SHALL have port pause, input, 1, level: freezes prescaler and all decay.
REQ-015 SHALL have port revive, input, 1, one-cycle pulse restoring the pet.
REQ-016 SHALL have port levels, output, NUM_STATS*STAT_W, packed levels, channel 0 in LSBs.
REQ-017 SHALL have port display_out, output, 4, {mood[1:0], idx[1:0]} figure code.
REQ-018 SHALL have port tick, output, 1, one-cycle pulse on each prescaler wrap.
REQ-019 SHALL have port alarm, output, 1, high in CRIT or DEAD.

Function
REQ-020 Prescaler SHALL count 0..DIV-1 (DIV per test), pulse tick in the wrap cycle; pause high holds count, no tick.
REQ-021 Any change of test SHALL clear prescaler to 0 in the following cycle, no tick emitted.
REQ-022 Each channel SHALL hold a decay counter incremented per tick; at DECAY_TICKS it clears and level decrements by 1, saturating at 0.
REQ-023 stim[i] SHALL increment level i by 1, saturating at MAX_LEVEL, and clear its decay counter; level visible one cycle after pulse.
REQ-024 stim[i] and decay of channel i in same cycle: stim wins, net +1 (saturating), counter cleared.
REQ-025 Mood FSM states OK(00), WARN(01), CRIT(10), DEAD(11); transitions evaluated every cycle on registered levels.
REQ-026 OK/WARN/CRIT selection: CRIT if any level = 0, else WARN if any level <= WARN_LVL, else OK; upward and downward moves allowed.
REQ-027 CRIT SHALL count ticks while resident; counter clears on leaving CRIT; reaching DEAD_TICKS enters DEAD.
REQ-028 DEAD SHALL be absorbing: stim ignored, decay frozen, levels held; exit only via revive or reset.
REQ-029 revive SHALL (any state) set all levels to INIT_LEVEL, clear decay and CRIT counters, enter OK next cycle; revive beats simultaneous stim.
REQ-030 idx SHALL be lowest channel index meeting the current state's condition (level 0 in CRIT/DEAD, <= WARN_LVL in WARN), 0 in OK.
REQ-031 display_out, alarm SHALL be registered, updating the cycle after the state change.

Reset
REQ-032 rst low SHALL asynchronously force levels=INIT_LEVEL, all counters 0, state OK, display_out=4'h0, tick=0, alarm=0; release synchronous to clk.
REQ-033 Reset mid-decay or in DEAD SHALL discard all progress; no tick in first cycle after release.

Structure
REQ-034 Mood encodings and display_out field layout SHALL live in shared package pet_pkg.
REQ-035 One sub-module pet_stat_channel (level + decay counter + stim/revive priority) SHALL be instantiated NUM_STATS times by generate.

Verification (TICK_DIV=4, TEST_DIV=2, DECAY_TICKS=3, MAX=INIT=5, WARN_LVL=2, DEAD_TICKS=2, NUM_STATS=4)
REQ-036 Release reset, idle 12 cycles -> tick at cycles 3,7,11; all levels 4 after cycle 11; display_out=0.
REQ-037 stim=4'b0001 at level 5 -> level0 stays 5, its decay counter cleared; stim coincident with decay at level 3 -> 4.
REQ-038 No stim until level2 hits 2 -> display_out=4'b0110; level2 hits 0 -> 4'b1010, alarm=1.
REQ-039 Hold CRIT 2 ticks -> display_out=4'b11xx, alarm=1; further stim leaves levels unchanged; revive -> levels all 5, display_out=0.
REQ-040 test toggled mid-count -> prescaler cleared, next tick after 2 cycles; pause high 10 cycles -> no tick, levels constant.
REQ-041 rst low during DEAD mid-cycle -> outputs reset immediately, independent of clk.
